// File: rtl/cpu_pkg.sv
// Shared widths and types for the 16-bit CPU datapath.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NREGS  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_idx_t REG_ZERO = 4'd0;

endpackage : cpu_pkg

// File: rtl/regfile_core.sv
// Architectural register storage: one write port, three raw read ports, R0 reads as zero.
module regfile_core
  import cpu_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_we,
  input  reg_idx_t i_waddr,
  input  word_t    i_wdata,
  input  reg_idx_t i_rs1_addr,
  input  reg_idx_t i_rs2_addr,
  input  reg_idx_t i_dbg_addr,
  output word_t    o_rs1_data,
  output word_t    o_rs2_data,
  output word_t    o_dbg_data
);

  word_t r_regs [NREGS];

  // Storage update; reset wins over any write on a coinciding edge, R0 never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != REG_ZERO)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Raw stored-value reads with R0 masked.
  always_comb begin
    o_rs1_data = (i_rs1_addr == REG_ZERO) ? '0 : r_regs[i_rs1_addr];
    o_rs2_data = (i_rs2_addr == REG_ZERO) ? '0 : r_regs[i_rs2_addr];
    o_dbg_data = (i_dbg_addr == REG_ZERO) ? '0 : r_regs[i_dbg_addr];
  end

endmodule : regfile_core

// File: rtl/wb_regfile.sv
// Write-back stage: data select, register commit, read bypass, forwarding, commit trace, retire count.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  word_t            wb_alu_result,
  input  word_t            wb_read_data,
  input  reg_idx_t         wb_rd,
  input  logic             wb_reg_write,
  input  logic             wb_mem_to_reg,
  input  reg_idx_t         rs1_addr,
  input  reg_idx_t         rs2_addr,
  output word_t            rs1_data,
  output word_t            rs2_data,
  output logic             fwd_en,
  output reg_idx_t         fwd_rd,
  output word_t            fwd_data,
  input  reg_idx_t         dbg_addr,
  output word_t            dbg_data,
  output logic             commit_valid,
  output reg_idx_t         commit_rd,
  output word_t            commit_data,
  output logic [CNT_W-1:0] retire_count
);

  word_t            w_wb_data;
  logic             w_do_write;
  word_t            w_rs1_raw;
  word_t            w_rs2_raw;
  logic             r_commit_valid;
  reg_idx_t         r_commit_rd;
  word_t            r_commit_data;
  logic [CNT_W-1:0] r_retire_count;

  // Write-back data select and effective write enable (R0 writes suppressed).
  always_comb begin
    w_wb_data  = wb_mem_to_reg ? wb_read_data : wb_alu_result;
    w_do_write = wb_valid & wb_reg_write & (wb_rd != REG_ZERO);
  end

  regfile_core u_core (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_do_write),
    .i_waddr    (wb_rd),
    .i_wdata    (w_wb_data),
    .i_rs1_addr (rs1_addr),
    .i_rs2_addr (rs2_addr),
    .i_dbg_addr (dbg_addr),
    .o_rs1_data (w_rs1_raw),
    .o_rs2_data (w_rs2_raw),
    .o_dbg_data (dbg_data)
  );

  // Operand reads with independent write-through bypass; R0 always zero.
  always_comb begin
    rs1_data = w_rs1_raw;
    rs2_data = w_rs2_raw;
    if (rs1_addr == REG_ZERO) begin
      rs1_data = '0;
    end else if (w_do_write && (wb_rd == rs1_addr)) begin
      rs1_data = w_wb_data;
    end
    if (rs2_addr == REG_ZERO) begin
      rs2_data = '0;
    end else if (w_do_write && (wb_rd == rs2_addr)) begin
      rs2_data = w_wb_data;
    end
  end

  // Forwarding to EX mirrors the in-flight write.
  always_comb begin
    fwd_en   = w_do_write;
    fwd_rd   = wb_rd;
    fwd_data = w_wb_data;
  end

  // Commit trace: pulse each committed write; index/data hold between commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_commit_valid <= 1'b0;
      r_commit_rd    <= '0;
      r_commit_data  <= '0;
    end else begin
      r_commit_valid <= w_do_write;
      if (w_do_write) begin
        r_commit_rd   <= wb_rd;
        r_commit_data <= w_wb_data;
      end
    end
  end

  // Retired-instruction counter: every valid slot counts, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire_count <= '0;
    end else if (wb_valid) begin
      r_retire_count <= r_retire_count + CNT_W'(1);
    end
  end

  assign commit_valid = r_commit_valid;
  assign commit_rd    = r_commit_rd;
  assign commit_data  = r_commit_data;
  assign retire_count = r_retire_count;

  // Simulation guard: a valid slot must never present an unknown write enable.
  always @(posedge clk) begin
    if (!rst && (wb_valid === 1'b1)) begin
      assert (!$isunknown(wb_reg_write))
        else $error("wb_reg_write unknown on a valid write-back slot");
    end
  end

endmodule : wb_regfile
